// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: per-pin direction, input synchroniser, atomic set/clear, and
// optional edge interrupts with write-1-to-clear status (present only when GPIO_IRQ_EN is defined).
module gpio_ctrl #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cs,
   input  logic             we,
   input  logic             re,
   input  logic [4:0]       addr,
   input  logic [31:0]      wdata,
   input  logic [3:0]       be,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   typedef enum logic [2:0] {
      REG_DATA_IN  = 3'd0,
      REG_DATA_OUT = 3'd1,
      REG_DIR      = 3'd2,
      REG_RISE_EN  = 3'd3,
      REG_FALL_EN  = 3'd4,
      REG_STATUS   = 3'd5,
      REG_OUT_SET  = 3'd6,
      REG_OUT_CLR  = 3'd7
   } reg_sel_e;

   reg_sel_e         sel;
   logic             wr_en;
   logic             rd_en;
   logic [31:0]      byte_mask;
   logic [31:0]      wr_bits_full;
   logic [WIDTH-1:0] wr_mask;
   logic [WIDTH-1:0] wr_bits;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_in;
   logic [31:0]      rd_word;
   logic             unused_addr_bits;

   assign sel              = reg_sel_e'(addr[4:2]);
   assign wr_en            = cs & we;
   assign rd_en            = cs & re;
   assign unused_addr_bits = ^addr[1:0];

   // Disabled bytes contribute zeros, so SET/CLR/W1C never act on them.
   assign byte_mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign wr_bits_full = wdata & byte_mask;
   assign wr_mask      = byte_mask[WIDTH-1:0];
   assign wr_bits      = wr_bits_full[WIDTH-1:0];

   function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_val,
                                                    input logic [WIDTH-1:0] mask,
                                                    input logic [WIDTH-1:0] bits);
      return (old_val & ~mask) | bits;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         dir      <= '0;
      end else if (wr_en) begin
         case (sel)
            REG_DATA_OUT: data_out <= merge_bytes(data_out, wr_mask, wr_bits);
            REG_OUT_SET:  data_out <= data_out | wr_bits;
            REG_OUT_CLR:  data_out <= data_out & ~wr_bits;
            REG_DIR:      dir      <= merge_bytes(dir, wr_mask, wr_bits);
            default:      ;
         endcase
      end
   end

   assign gpio_out = data_out;
   assign gpio_oe  = dir;

`ifdef GPIO_IRQ_EN
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_status;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] w1c;

   assign edge_set = (sync_in & ~prev & rise_en) | (~sync_in & prev & fall_en);
   assign w1c      = (wr_en && sel == REG_STATUS) ? wr_bits : '0;

   // A new edge in the same cycle as a clear keeps the status bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev       <= '0;
         rise_en    <= '0;
         fall_en    <= '0;
         irq_status <= '0;
      end else begin
         prev       <= sync_in;
         irq_status <= (irq_status & ~w1c) | edge_set;
         if (wr_en && sel == REG_RISE_EN) rise_en <= merge_bytes(rise_en, wr_mask, wr_bits);
         if (wr_en && sel == REG_FALL_EN) fall_en <= merge_bytes(fall_en, wr_mask, wr_bits);
      end
   end

   assign irq = |irq_status;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_word = '0;
      case (sel)
         REG_DATA_IN:  rd_word = 32'(sync_in);
         REG_DATA_OUT: rd_word = 32'(data_out);
         REG_DIR:      rd_word = 32'(dir);
`ifdef GPIO_IRQ_EN
         REG_RISE_EN:  rd_word = 32'(rise_en);
         REG_FALL_EN:  rd_word = 32'(fall_en);
         REG_STATUS:   rd_word = 32'(irq_status);
`endif
         default:      rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= rd_word;
      end
   end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: a 32-pin and an 8-pin instance on a shared bus, table-driven
// register vectors plus hand-written timing sequences; builds with or without GPIO_IRQ_EN.
module tb_gpio_ctrl;

`ifdef GPIO_IRQ_EN
   localparam logic [31:0] IRQ_MASK = 32'hFFFF_FFFF;
   localparam logic        EXP_IRQ  = 1'b1;
`else
   localparam logic [31:0] IRQ_MASK = 32'h0;
   localparam logic        EXP_IRQ  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs32 = 1'b0, cs8 = 1'b0, we = 1'b0, re = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic [31:0] rdata32, rdata8;
   logic [31:0] gpio_in32 = '0, gpio_out32, gpio_oe32;
   logic [7:0]  gpio_in8 = '0, gpio_out8, gpio_oe8;
   logic        irq32, irq8;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
      .clk(clk), .rst_n(rst_n), .cs(cs32), .we(we), .re(re), .addr(addr),
      .wdata(wdata), .be(be), .rdata(rdata32), .gpio_in(gpio_in32),
      .gpio_out(gpio_out32), .gpio_oe(gpio_oe32), .irq(irq32)
   );

   gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .cs(cs8), .we(we), .re(re), .addr(addr),
      .wdata(wdata), .be(be), .rdata(rdata8), .gpio_in(gpio_in8),
      .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
   );

   typedef struct {
      bit          inst8;
      bit          is_write;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic [31:0] exp_out;
      logic [31:0] exp_oe;
   } vec_t;

   vec_t vecs[$];

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic add_vec(input bit i8, input bit w, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] er, input logic [31:0] eo,
                          input logic [31:0] ee);
      vec_t v;
      v.inst8 = i8; v.is_write = w; v.addr = a; v.wdata = d; v.be = b;
      v.exp_rd = er; v.exp_out = eo; v.exp_oe = ee;
      vecs.push_back(v);
   endtask

   // One bus transaction: driven after a falling edge, sampled at the following falling edge.
   task automatic apply_stimulus(input bit i8, input bit w, input logic [4:0] a,
                                 input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      cs32 = !i8; cs8 = i8; we = w; re = !w; addr = a; wdata = d; be = b;
      @(negedge clk);
      cs32 = 1'b0; cs8 = 1'b0; we = 1'b0; re = 1'b0;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      apply_stimulus(1'b0, 1'b1, a, d, 4'hF);
   endtask

   initial begin
      add_vec(0, 0, 5'h00, 0, 0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 0, 5'h04, 0, 0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 0, 5'h08, 0, 0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 0, 5'h0C, 0, 0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 0, 5'h10, 0, 0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 0, 5'h14, 0, 0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 0, 5'h18, 0, 0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 0, 5'h1C, 0, 0, 32'h0, 32'h0, 32'h0);
      add_vec(0, 1, 5'h04, 32'h0000_00FF, 4'b0001, 0, 32'h0000_00FF, 32'h0);
      add_vec(0, 1, 5'h04, 32'hFFFF_FFFF, 4'b0010, 0, 32'h0000_FFFF, 32'h0);
      add_vec(0, 0, 5'h04, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0);
      add_vec(0, 1, 5'h1C, 32'h0000_000F, 4'hF, 0, 32'h0000_FFF0, 32'h0);
      add_vec(0, 0, 5'h04, 0, 0, 32'h0000_FFF0, 32'h0000_FFF0, 32'h0);
      add_vec(0, 1, 5'h18, 32'h8000_0000, 4'hF, 0, 32'h8000_FFF0, 32'h0);
      add_vec(0, 0, 5'h04, 0, 0, 32'h8000_FFF0, 32'h8000_FFF0, 32'h0);
      add_vec(0, 1, 5'h18, 32'hFFFF_FFFF, 4'b0000, 0, 32'h8000_FFF0, 32'h0);
      add_vec(0, 1, 5'h1C, 32'hFFFF_FFFF, 4'b1000, 0, 32'h0000_FFF0, 32'h0);
      add_vec(0, 0, 5'h04, 0, 0, 32'h0000_FFF0, 32'h0000_FFF0, 32'h0);
      add_vec(0, 0, 5'h18, 0, 0, 32'h0, 32'h0000_FFF0, 32'h0);
      add_vec(0, 1, 5'h08, 32'h1234_5678, 4'hF, 0, 32'h0000_FFF0, 32'h1234_5678);
      add_vec(0, 0, 5'h08, 0, 0, 32'h1234_5678, 32'h0000_FFF0, 32'h1234_5678);
      add_vec(0, 1, 5'h00, 32'hFFFF_FFFF, 4'hF, 0, 32'h0000_FFF0, 32'h1234_5678);
      add_vec(0, 0, 5'h00, 0, 0, 32'h0, 32'h0000_FFF0, 32'h1234_5678);
      add_vec(0, 1, 5'h0C, 32'hFFFF_FFFF, 4'hF, 0, 32'h0000_FFF0, 32'h1234_5678);
      add_vec(0, 0, 5'h0C, 0, 0, IRQ_MASK, 32'h0000_FFF0, 32'h1234_5678);
      add_vec(0, 1, 5'h0C, 32'h0, 4'hF, 0, 32'h0000_FFF0, 32'h1234_5678);
      add_vec(1, 1, 5'h08, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 32'h0000_00FF);
      add_vec(1, 0, 5'h08, 0, 0, 32'h0000_00FF, 32'h0, 32'h0000_00FF);
      add_vec(1, 0, 5'h1C, 0, 0, 32'h0, 32'h0, 32'h0000_00FF);
      add_vec(1, 1, 5'h00, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 32'h0000_00FF);
      add_vec(1, 0, 5'h08, 0, 0, 32'h0000_00FF, 32'h0, 32'h0000_00FF);
      add_vec(1, 1, 5'h04, 32'hFFFF_FFFF, 4'b0101, 0, 32'h0000_00FF, 32'h0000_00FF);
      add_vec(1, 0, 5'h04, 0, 0, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF);

      repeat (3) @(negedge clk);
      check_output("reset rdata", rdata32, 32'h0);
      check_output("reset irq", {31'b0, irq32}, 32'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].inst8, vecs[i].is_write, vecs[i].addr, vecs[i].wdata, vecs[i].be);
         if (!vecs[i].is_write)
            check_output($sformatf("vec%0d rdata", i), vecs[i].inst8 ? rdata8 : rdata32, vecs[i].exp_rd);
         check_output($sformatf("vec%0d gpio_out", i),
                      vecs[i].inst8 ? {24'b0, gpio_out8} : gpio_out32, vecs[i].exp_out);
         check_output($sformatf("vec%0d gpio_oe", i),
                      vecs[i].inst8 ? {24'b0, gpio_oe8} : gpio_oe32, vecs[i].exp_oe);
         check_output($sformatf("vec%0d irq", i), {31'b0, irq32}, 32'h0);
      end

      // Strobes without select must leave rdata and registers alone.
      apply_stimulus(0, 0, 5'h04, 0, 0);
      check_output("read before hold", rdata32, 32'h0000_FFF0);
      @(negedge clk);
      cs32 = 1'b0; we = 1'b1; re = 1'b1; addr = 5'h08; wdata = 32'h0; be = 4'hF;
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      check_output("no-cs rdata hold", rdata32, 32'h0000_FFF0);
      check_output("no-cs dir hold", gpio_oe32, 32'h1234_5678);

      // Simultaneous read and write returns the pre-write value.
      @(negedge clk);
      cs32 = 1'b1; we = 1'b1; re = 1'b1; addr = 5'h04; wdata = 32'h0000_0001; be = 4'hF;
      @(negedge clk);
      cs32 = 1'b0; we = 1'b0; re = 1'b0;
      check_output("rd+wr rdata", rdata32, 32'h0000_FFF0);
      check_output("rd+wr gpio_out", gpio_out32, 32'h0000_0001);

      // Rising edge on pin 0: DATA_IN after edge k+1 is readable at k+2, status sets at k+2.
      bus_write(5'h0C, 32'h1);
      @(negedge clk);
      gpio_in32[0] = 1'b1;
      cs32 = 1'b1; re = 1'b1; we = 1'b0; addr = 5'h00;
      @(negedge clk);
      @(negedge clk);
      check_output("data_in k+1", {31'b0, rdata32[0]}, 32'h0);
      check_output("irq k+1", {31'b0, irq32}, 32'h0);
      @(negedge clk);
      check_output("data_in k+2", {31'b0, rdata32[0]}, 32'h1);
      check_output("irq k+2", {31'b0, irq32}, {31'b0, EXP_IRQ});
      cs32 = 1'b0; re = 1'b0;
      apply_stimulus(0, 0, 5'h14, 0, 0);
      check_output("status after rise", rdata32, 32'h1 & IRQ_MASK);
      bus_write(5'h14, 32'h1);
      check_output("irq after w1c", {31'b0, irq32}, 32'h0);

      // Falling edge on pin 1 whose set cycle coincides with a W1C of the same bit.
      bus_write(5'h10, 32'h2);
      @(negedge clk);
      gpio_in32[1] = 1'b1;
      repeat (4) @(negedge clk);
      gpio_in32[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      cs32 = 1'b1; we = 1'b1; re = 1'b0; addr = 5'h14; wdata = 32'h2; be = 4'hF;
      @(negedge clk);
      cs32 = 1'b0; we = 1'b0;
      check_output("irq set beats w1c", {31'b0, irq32}, {31'b0, EXP_IRQ});
      apply_stimulus(0, 0, 5'h14, 0, 0);
      check_output("status set beats w1c", rdata32, 32'h2 & IRQ_MASK);
      bus_write(5'h14, 32'h2);
      apply_stimulus(0, 0, 5'h14, 0, 0);
      check_output("status cleared", rdata32, 32'h0);
      check_output("irq cleared", {31'b0, irq32}, 32'h0);

      // Asynchronous reset mid-operation clears state without waiting for a clock edge.
      apply_stimulus(0, 0, 5'h08, 0, 0);
      check_output("read before reset", rdata32, 32'h1234_5678);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("async reset rdata", rdata32, 32'h0);
      check_output("async reset gpio_out", gpio_out32, 32'h0);
      check_output("async reset gpio_oe", gpio_oe32, 32'h0);
      check_output("async reset gpio_oe8", {24'b0, gpio_oe8}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
